// File: rtl/ristretto_pcu_pkg.sv
// Shared types and constants for the ristretto pipeline control unit.
package ristretto_pcu_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    MULTI = 2'b01,
    WAIT  = 2'b10,
    FLUSH = 2'b11
  } pcu_state_t;

  typedef enum logic [1:0] {
    PEN_NONE   = 2'b00,
    PEN_LONG   = 2'b01,
    PEN_BUBBLE = 2'b10,
    PEN_VAR    = 2'b11
  } penality_code_t;

  // Penalty code a flushed slot carries out of the decode/execute register.
  localparam penality_code_t DEC_EXE_FLUSH_PEN = PEN_BUBBLE;

  // Wide enough for LongLatCycles-1 (max 14) and FlushCycles-1 (max 2).
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/ristretto_pcu_counter.sv
// Loadable down-counter with zero flag; stops at zero instead of wrapping.
module ristretto_pcu_counter
  import ristretto_pcu_pkg::*;
#(
  parameter int unsigned Width = CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o,
  output logic             zero_o
);

  localparam logic [Width-1:0] CntZero = {Width{1'b0}};
  localparam logic [Width-1:0] CntOne  = Width'(1);

  logic [Width-1:0] count_r;

  // Count register: clear beats load beats decrement.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_r <= CntZero;
    end else if (clr_i) begin
      count_r <= CntZero;
    end else if (load_i) begin
      count_r <= load_val_i;
    end else if (dec_i && (count_r != CntZero)) begin
      count_r <= count_r - CntOne;
    end else begin
      count_r <= count_r;
    end
  end

  assign count_o = count_r;
  assign zero_o  = (count_r == CntZero);

endmodule

// File: rtl/ristretto_pipe_ctrl_unit.sv
// Pipeline control unit: stall/flush sequencing for the IF/DEC and DEC/EXE
// registers driven by execute-stage penalties, redirects, hazards and LSU stalls.
module ristretto_pipe_ctrl_unit
  import ristretto_pcu_pkg::*;
#(
  parameter int unsigned LongLatCycles = 2,
  parameter int unsigned FlushCycles   = 2,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       exe_new_instr_i,
  input  logic [1:0] exe_penality_i,
  input  logic       exe_done_i,
  input  logic       exe_redirect_i,
  input  logic       dec_hazard_i,
  input  logic       lsu_stall_i,
  output logic       pc_stall_o,
  output logic       if_dec_stall_o,
  output logic       dec_exe_stall_o,
  output logic       if_dec_flush_o,
  output logic       dec_exe_flush_o,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  localparam logic [CNT_W-1:0] LongLoad  = CNT_W'(LongLatCycles - 1);
  localparam logic [CNT_W-1:0] FlushLoad = CNT_W'(FlushCycles - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
  localparam logic [TmoW-1:0]  TmoZero   = {TmoW{1'b0}};
  localparam logic [TmoW-1:0]  TmoOne    = TmoW'(1);
  localparam logic [TmoW-1:0]  TmoMax    = TmoW'(TimeoutCycles);
  localparam logic [TmoW-1:0]  TmoLast   = TmoW'(TimeoutCycles - 1);

  pcu_state_t     state_r, state_s;
  penality_code_t pen_s;
  logic           quiet_r, busy_r, timeout_r;
  logic [TmoW-1:0]  tmo_cnt_r;
  logic [CNT_W-1:0] multi_cnt_s, flush_cnt_s;
  logic multi_zero_s, flush_zero_s;
  logic stall_s, flush_s, hazard_s;
  logic multi_load_s, multi_dec_s, multi_clr_s, flush_load_s, flush_dec_s;
  logic tmo_clr_s, tmo_inc_s, tmo_set_s;

  ristretto_pcu_counter #(.Width(CNT_W)) u_multi_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(multi_clr_s), .load_i(multi_load_s),
    .load_val_i(LongLoad), .dec_i(multi_dec_s), .count_o(multi_cnt_s), .zero_o(multi_zero_s)
  );

  ristretto_pcu_counter #(.Width(CNT_W)) u_flush_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(1'b0), .load_i(flush_load_s),
    .load_val_i(FlushLoad), .dec_i(flush_dec_s), .count_o(flush_cnt_s), .zero_o(flush_zero_s)
  );

  // Next state and combinational stall/flush decisions; quiet_r keeps the cycle after reset idle.
  always_comb begin
    state_s = state_r;
    pen_s = penality_code_t'(exe_penality_i);
    stall_s = 1'b0;
    flush_s = 1'b0;
    hazard_s = 1'b0;
    multi_load_s = 1'b0;
    multi_dec_s = 1'b0;
    multi_clr_s = 1'b0;
    flush_load_s = 1'b0;
    flush_dec_s = 1'b0;
    tmo_clr_s = 1'b0;
    tmo_inc_s = 1'b0;
    tmo_set_s = 1'b0;
    if (rst_i || quiet_r) begin
      state_s = RUN;
    end else if (exe_redirect_i) begin
      flush_s = 1'b1;
      multi_clr_s = 1'b1;
      tmo_clr_s = 1'b1;
      if (FlushCycles > 1) begin
        flush_load_s = 1'b1;
        state_s = FLUSH;
      end else begin
        state_s = RUN;
      end
    end else if (lsu_stall_i && (state_r != FLUSH)) begin
      stall_s = 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (exe_new_instr_i) begin
            case (pen_s)
              PEN_LONG: begin
                stall_s = 1'b1;
                if (LongLatCycles > 1) begin
                  multi_load_s = 1'b1;
                  state_s = MULTI;
                end else begin
                  state_s = RUN;
                end
              end
              PEN_VAR: begin
                if (!exe_done_i) begin
                  stall_s = 1'b1;
                  tmo_clr_s = 1'b1;
                  state_s = WAIT;
                end else begin
                  state_s = RUN;
                end
              end
              default: state_s = RUN;
            endcase
          end else begin
            state_s = RUN;
          end
          // A concurrent stall already holds decode, so the bubble is only injected otherwise.
          hazard_s = dec_hazard_i && !stall_s;
        end
        MULTI: begin
          stall_s = 1'b1;
          multi_dec_s = 1'b1;
          if ((multi_cnt_s == CntOne) || multi_zero_s) begin
            state_s = RUN;
          end else begin
            state_s = MULTI;
          end
        end
        WAIT: begin
          if (exe_done_i) begin
            state_s = RUN;
          end else begin
            stall_s = 1'b1;
            tmo_inc_s = 1'b1;
            if (tmo_cnt_r >= TmoLast) begin
              tmo_set_s = 1'b1;
              state_s = RUN;
            end else begin
              state_s = WAIT;
            end
          end
        end
        FLUSH: begin
          flush_s = 1'b1;
          flush_dec_s = 1'b1;
          if ((flush_cnt_s <= CntOne) || flush_zero_s) begin
            state_s = RUN;
          end else begin
            state_s = FLUSH;
          end
        end
        default: state_s = RUN;
      endcase
    end
  end

  // State, post-reset quiet flag and registered status outputs.
  always_ff @(posedge clk_i) begin
    quiet_r <= rst_i;
    if (rst_i) begin
      state_r   <= RUN;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      busy_r    <= (state_s != RUN);
      timeout_r <= timeout_r | tmo_set_s;
    end
  end

  // Saturating timeout counter for the variable-latency wait.
  always_ff @(posedge clk_i) begin
    if (rst_i || tmo_clr_s) begin
      tmo_cnt_r <= TmoZero;
    end else if (tmo_inc_s && (tmo_cnt_r != TmoMax)) begin
      tmo_cnt_r <= tmo_cnt_r + TmoOne;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  assign pc_stall_o      = stall_s | hazard_s;
  assign if_dec_stall_o  = stall_s | hazard_s;
  assign dec_exe_stall_o = stall_s;
  assign if_dec_flush_o  = flush_s;
  assign dec_exe_flush_o = flush_s | hazard_s;
  assign busy_o          = busy_r & ~rst_i;
  assign timeout_o       = timeout_r & ~rst_i;

endmodule

// File: tb/tb_ristretto_pipe_ctrl_unit.sv
// Directed bench for ristretto_pipe_ctrl_unit (LongLat=2, Flush=2, Timeout=4).
module tb_ristretto_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       exe_new_instr_i = 1'b0;
  logic [1:0] exe_penality_i = 2'b00;
  logic       exe_done_i = 1'b0;
  logic       exe_redirect_i = 1'b0;
  logic       dec_hazard_i = 1'b0;
  logic       lsu_stall_i = 1'b0;
  logic pc_stall_o, if_dec_stall_o, dec_exe_stall_o, if_dec_flush_o, dec_exe_flush_o;
  logic busy_o, timeout_o;
  int vectors = 0;
  int miscompares = 0;

  ristretto_pipe_ctrl_unit #(.LongLatCycles(2), .FlushCycles(2), .TimeoutCycles(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .exe_new_instr_i(exe_new_instr_i),
    .exe_penality_i(exe_penality_i), .exe_done_i(exe_done_i),
    .exe_redirect_i(exe_redirect_i), .dec_hazard_i(dec_hazard_i),
    .lsu_stall_i(lsu_stall_i), .pc_stall_o(pc_stall_o),
    .if_dec_stall_o(if_dec_stall_o), .dec_exe_stall_o(dec_exe_stall_o),
    .if_dec_flush_o(if_dec_flush_o), .dec_exe_flush_o(dec_exe_flush_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // Expected vector bits: {pc_stall, if_dec_stall, dec_exe_stall, if_dec_flush, dec_exe_flush, busy, timeout}
  localparam logic [6:0] IDLE = 7'b0000000;
  localparam logic [6:0] STL  = 7'b1110000;
  localparam logic [6:0] FLS  = 7'b0001100;
  localparam logic [6:0] BSY  = 7'b0000010;
  localparam logic [6:0] TMO  = 7'b0000001;
  localparam logic [6:0] HAZ  = 7'b1100100;

  // One cycle: drive inputs after the edge, check at the falling edge.
  task automatic step(input string tag, input logic ni, input logic [1:0] pen,
                      input logic done, input logic redir, input logic haz,
                      input logic lsu, input logic [6:0] exp);
    logic [6:0] obs;
    exe_new_instr_i = ni;
    exe_penality_i  = pen;
    exe_done_i      = done;
    exe_redirect_i  = redir;
    dec_hazard_i    = haz;
    lsu_stall_i     = lsu;
    @(negedge clk);
    obs = {pc_stall_o, if_dec_stall_o, dec_exe_stall_o, if_dec_flush_o,
           dec_exe_flush_o, busy_o, timeout_o};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset must mask active inputs, then one quiet cycle.
    step("rst_masks",    1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, IDLE);
    rst_i = 1'b0;
    step("post_rst",     1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
    step("idle",         1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
    // Long latency: stall t..t+1, busy only at t+1.
    step("long_t0",      1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, STL);
    step("long_t1",      1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, STL | BSY);
    step("long_t2",      1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
    step("pen_none",     1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
    // Variable latency, done on the fifth cycle.
    step("var_t0",       1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, STL);
    step("var_t1",       1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, STL | BSY);
    step("var_t2",       1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, STL | BSY);
    step("var_t3",       1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, STL | BSY);
    step("var_done",     1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, BSY);
    step("var_after",    1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
    step("var_same_cyc", 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, IDLE);
    step("var_same_nx",  1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
    // Timeout: rises five cycles after the pulse and sticks.
    step("tmo_t0",       1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, STL);
    step("tmo_t1",       1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, STL | BSY);
    step("tmo_t2",       1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, STL | BSY);
    step("tmo_t3",       1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, STL | BSY);
    step("tmo_t4",       1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, STL | BSY);
    step("tmo_t5",       1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, TMO);
    step("tmo_bubble",   1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, TMO);
    // Redirect while in MULTI: flush two cycles, RUN afterwards.
    step("rdr_long",     1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, STL | TMO);
    step("rdr_t0",       1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, FLS | BSY | TMO);
    step("rdr_t1",       1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, FLS | BSY | TMO);
    step("rdr_t2",       1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, TMO);
    // Load-use hazard alone, then together with a redirect.
    step("haz_only",     1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, HAZ | TMO);
    step("haz_after",    1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, TMO);
    step("haz_rdr",      1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, FLS | TMO);
    step("haz_rdr_t1",   1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, FLS | BSY | TMO);
    step("haz_rdr_t2",   1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, TMO);
    // LSU stall ignored in FLUSH.
    step("lsu_rdr",      1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, FLS | TMO);
    step("lsu_in_flush", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, FLS | BSY | TMO);
    step("lsu_run",      1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, STL | TMO);
    step("lsu_off",      1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, TMO);
    // LSU stall for 3 cycles inside MULTI extends the stall to 5 cycles.
    step("lsu_m_t0",     1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, STL | TMO);
    step("lsu_m_t1",     1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, STL | BSY | TMO);
    step("lsu_m_t2",     1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, STL | BSY | TMO);
    step("lsu_m_t3",     1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, STL | BSY | TMO);
    step("lsu_m_t4",     1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, STL | BSY | TMO);
    step("lsu_m_t5",     1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, TMO);
    // Reset clears the sticky timeout.
    rst_i = 1'b1;
    step("rst_mid",      1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
    rst_i = 1'b0;
    step("rst_after",    1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
    step("rst_idle",     1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
